// File: rtl/osd_dem_uart_pkg.sv
// Shared constants, flit field offsets and FSM state encoding for the UART
// device-emulation receive path.
package osd_dem_uart_pkg;

    localparam logic [1:0] OSD_TYPE_EVENT = 2'b10;
    localparam logic [3:0] UART_SUB_DATA  = 4'h0;

    localparam int HDR_TYPE_MSB = 15;
    localparam int HDR_TYPE_LSB = 14;
    localparam int HDR_SUB_MSB  = 13;
    localparam int HDR_SUB_LSB  = 10;
    localparam int CHAR_MSB     = 7;

    typedef enum logic [2:0] {
        S_DEST = 3'd0,
        S_SRC  = 3'd1,
        S_HDR  = 3'd2,
        S_PAY  = 3'd3,
        S_DROP = 3'd4
    } state_t;

    function automatic logic hdr_ok(input logic [15:0] hdr);
        return (hdr[HDR_TYPE_MSB:HDR_TYPE_LSB] == OSD_TYPE_EVENT) &&
               (hdr[HDR_SUB_MSB:HDR_SUB_LSB] == UART_SUB_DATA);
    endfunction

endpackage

// File: rtl/osd_dem_uart_rx_if.sv
// Ring-flit input and character-stream output of the UART receive block.
interface osd_dem_uart_rx_if;

    logic [15:0] dii_data;
    logic        dii_last;
    logic        dii_valid;
    logic        dii_ready;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready;

    modport slave (
        input  dii_data, dii_last, dii_valid, char_ready,
        output dii_ready, char_out, char_valid
    );

    modport master (
        output dii_data, dii_last, dii_valid, char_ready,
        input  dii_ready, char_out, char_valid
    );

endinterface

// File: rtl/dem_uart_char_fifo.sv
// First-word-fall-through character FIFO; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate occupancy counter.
module dem_uart_char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;
    // Head is forced to zero while empty so the output is defined out of reset.
    assign data_o    = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_s) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/osd_dem_uart_rx.sv
// Parses DII packets addressed to this module and unpacks UART data payload
// flits into a byte stream, counting dropped and malformed packets.
module osd_dem_uart_rx
    import osd_dem_uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       id_i,
    osd_dem_uart_rx_if.slave bus,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    state_t           state_q, state_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             drop_inc_s, err_inc_s;
    logic             beat_s, push_s, fifo_full_s, fifo_empty_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) return v + {{(CNT_W-1){1'b0}}, 1'b1};
        else                            return v;
    endfunction

    assign beat_s = bus.dii_valid && bus.dii_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_DEST;
            match_q <= 1'b0;
            drop_q  <= {CNT_W{1'b0}};
            err_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    // Next state; a drop or error is flagged exactly once per packet.
    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        drop_inc_s = 1'b0;
        err_inc_s  = 1'b0;
        case (state_q)
            S_DEST: if (beat_s) begin
                if (bus.dii_last) begin
                    err_inc_s = 1'b1;
                end else begin
                    match_d = (bus.dii_data == {6'b0, id_i});
                    state_d = S_SRC;
                end
            end
            S_SRC: if (beat_s) begin
                if (bus.dii_last) begin
                    err_inc_s = 1'b1;
                    state_d   = S_DEST;
                end else begin
                    state_d = S_HDR;
                end
            end
            S_HDR: if (beat_s) begin
                if (!match_q || !hdr_ok(bus.dii_data)) begin
                    drop_inc_s = 1'b1;
                    state_d    = bus.dii_last ? S_DEST : S_DROP;
                end else begin
                    state_d = bus.dii_last ? S_DEST : S_PAY;
                end
            end
            S_PAY:   if (beat_s && bus.dii_last) state_d = S_DEST;
            S_DROP:  if (beat_s && bus.dii_last) state_d = S_DEST;
            default: state_d = S_DEST;
        endcase
        drop_d = sat_inc(drop_q, drop_inc_s);
        err_d  = sat_inc(err_q, err_inc_s);
    end

    always_comb begin
        bus.dii_ready = (state_q == S_PAY) ? !fifo_full_s : 1'b1;
        push_s        = beat_s && (state_q == S_PAY);
    end

    assign bus.char_valid = !fifo_empty_s;
    assign drop_cnt_o     = drop_q;
    assign err_cnt_o      = err_q;

    dem_uart_char_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .data_i  (bus.dii_data[CHAR_MSB:0]),
        .full_o  (fifo_full_s),
        .pop_i   (bus.char_ready),
        .data_o  (bus.char_out),
        .empty_o (fifo_empty_s)
    );

endmodule

// File: tb/tb_osd_dem_uart_rx.sv
// Directed bench for osd_dem_uart_rx; a second instance with 4-bit counters
// sees every accepted beat of the first and exercises counter saturation.
module tb_osd_dem_uart_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  id  = 10'd2;
    logic [15:0] drop_cnt, err_cnt;
    logic [3:0]  sat_drop, sat_err;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 1;
    int acc_cnt  = 0;
    logic [7:0] rx_q[$];

    osd_dem_uart_rx_if bus();
    osd_dem_uart_rx_if sat_bus();

    always #5 clk = ~clk;

    osd_dem_uart_rx #(.DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_i(id), .bus(bus),
        .drop_cnt_o(drop_cnt), .err_cnt_o(err_cnt)
    );

    assign sat_bus.dii_data   = bus.dii_data;
    assign sat_bus.dii_last   = bus.dii_last;
    assign sat_bus.dii_valid  = bus.dii_valid & bus.dii_ready;
    assign sat_bus.char_ready = 1'b1;

    osd_dem_uart_rx #(.DEPTH(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_i(id), .bus(sat_bus),
        .drop_cnt_o(sat_drop), .err_cnt_o(sat_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Consumer ready: constant, or pseudo-random in mode 2.
    initial begin
        logic [15:0] lfsr = 16'hACE1;
        bus.char_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (rdy_mode == 2) bus.char_ready = lfsr[0];
            else               bus.char_ready = (rdy_mode == 1);
        end
    end

    // Record handshakes mid-cycle, where both sides are stable.
    always @(negedge clk) begin
        if (bus.char_valid && bus.char_ready) rx_q.push_back(bus.char_out);
        if (bus.dii_valid && bus.dii_ready) acc_cnt++;
    end

    task automatic send_flit(input logic [15:0] d, input bit last);
        bit ok = 1'b0;
        bus.dii_data  = d;
        bus.dii_last  = last;
        bus.dii_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.dii_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("flit_accept", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        bus.dii_valid = 1'b0;
        bus.dii_last  = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] f[$]);
        for (int i = 0; i < f.size(); i++) send_flit(f[i], i == f.size() - 1);
    endtask

    task automatic check_chars(input string tag, input int base, input logic [15:0] exp[$]);
        check_eq({tag, "_count"}, rx_q.size() - base, exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < rx_q.size()) check_eq(tag, rx_q[base + i], exp[i][7:0]);
        end
    endtask

    initial begin
        logic [15:0] pkt[$];
        logic [15:0] exp[$];
        int base, acc0;

        bus.dii_data  = 16'h0000;
        bus.dii_last  = 1'b0;
        bus.dii_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_dii_ready", bus.dii_ready, 1);
        check_eq("rst_char_valid", bus.char_valid, 0);
        check_eq("rst_char_out", bus.char_out, 0);
        check_eq("rst_drop", drop_cnt, 0);
        check_eq("rst_err", err_cnt, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: basic delivery and one-cycle push-to-valid latency
        base = rx_q.size();
        send_flit(16'h0002, 1'b0);
        send_flit(16'h0000, 1'b0);
        send_flit(16'h8000, 1'b0);
        bus.dii_data = 16'h0048; bus.dii_last = 1'b0; bus.dii_valid = 1'b1;
        @(negedge clk);
        check_eq("t1_valid_before", bus.char_valid, 0);
        @(posedge clk); #1;
        bus.dii_valid = 1'b0;
        @(negedge clk);
        check_eq("t1_valid_after", bus.char_valid, 1);
        check_eq("t1_first_char", bus.char_out, 8'h48);
        @(posedge clk); #1;
        send_flit(16'h0065, 1'b0);
        send_flit(16'h006c, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        exp = {16'h48, 16'h65, 16'h6c};
        check_chars("t1_char", base, exp);
        check_eq("t1_drop", drop_cnt, 0);
        check_eq("t1_err", err_cnt, 0);

        // 2: wrong destination is swallowed, next good packet delivered
        base = rx_q.size();
        acc0 = acc_cnt;
        pkt = {16'h0003, 16'h0000, 16'h8000, 16'h0048, 16'h0065, 16'h006c};
        send_pkt(pkt);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t2_no_chars", rx_q.size() - base, 0);
        check_eq("t2_accepted", acc_cnt - acc0, 6);
        check_eq("t2_drop", drop_cnt, 1);
        pkt = {16'h0002, 16'h0000, 16'h8000, 16'h0041, 16'h0042};
        send_pkt(pkt);
        repeat (4) @(posedge clk);
        #1;
        exp = {16'h41, 16'h42};
        check_chars("t2_char", base, exp);

        // 3: stalled consumer fills the FIFO and backpressures the ring
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        base = rx_q.size();
        acc0 = acc_cnt;
        pkt = {16'h0002, 16'h0000, 16'h8000};
        exp = {};
        for (int i = 0; i < 12; i++) begin
            pkt.push_back(16'h0030 + 16'(i));
            exp.push_back(16'h0030 + 16'(i));
        end
        fork
            send_pkt(pkt);
            begin
                repeat (25) @(negedge clk);
                check_eq("t3_ready_low", bus.dii_ready, 0);
                check_eq("t3_accepted", acc_cnt - acc0, 11);
                check_eq("t3_no_pop", rx_q.size() - base, 0);
                check_eq("t3_char_valid", bus.char_valid, 1);
                rdy_mode = 1;
            end
        join
        repeat (15) @(posedge clk);
        #1;
        check_chars("t3_char", base, exp);

        // 4: random consumer readiness across several pointer wraps
        rdy_mode = 2;
        base = rx_q.size();
        pkt = {16'h0002, 16'h0000, 16'h8000};
        exp = {};
        for (int i = 0; i < 40; i++) begin
            pkt.push_back(16'hAB00 + 16'((i * 37 + 5) & 8'hFF));
            exp.push_back(16'(((i * 37 + 5) & 8'hFF)));
        end
        send_pkt(pkt);
        rdy_mode = 1;
        repeat (15) @(posedge clk);
        #1;
        check_chars("t4_char", base, exp);

        // 5: malformed and header-only packets
        pkt = {16'h0002};
        send_pkt(pkt);
        pkt = {16'h0002, 16'h0000};
        send_pkt(pkt);
        check_eq("t5_err", err_cnt, 2);
        check_eq("t5_drop", drop_cnt, 1);
        base = rx_q.size();
        pkt = {16'h0002, 16'h0000, 16'h8000};
        send_pkt(pkt);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t5_hdr_only_chars", rx_q.size() - base, 0);
        check_eq("t5_hdr_only_err", err_cnt, 2);
        check_eq("t5_hdr_only_drop", drop_cnt, 1);
        pkt = {16'h0002, 16'h0000, 16'h8000, 16'h005A};
        send_pkt(pkt);
        repeat (3) @(posedge clk);
        #1;
        exp = {16'h5A};
        check_chars("t5_char", base, exp);

        // 6: asynchronous reset mid-payload, then counter saturation
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        send_flit(16'h0002, 1'b0);
        send_flit(16'h0000, 1'b0);
        send_flit(16'h8000, 1'b0);
        send_flit(16'h0061, 1'b0);
        send_flit(16'h0062, 1'b0);
        send_flit(16'h0063, 1'b0);
        check_eq("t6_queued", bus.char_valid, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_rst_char_valid", bus.char_valid, 0);
        check_eq("t6_rst_char_out", bus.char_out, 0);
        check_eq("t6_rst_drop", drop_cnt, 0);
        check_eq("t6_rst_err", err_cnt, 0);
        check_eq("t6_rst_ready", bus.dii_ready, 1);
        rdy_mode = 1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        base = rx_q.size();
        pkt = {16'h0002, 16'h0000, 16'h8000, 16'h0031, 16'h0032};
        send_pkt(pkt);
        repeat (4) @(posedge clk);
        #1;
        exp = {16'h31, 16'h32};
        check_chars("t6_char", base, exp);
        pkt = {16'h0005, 16'h0000, 16'h8000};
        for (int i = 0; i < 20; i++) send_pkt(pkt);
        pkt = {16'h0002};
        for (int i = 0; i < 17; i++) send_pkt(pkt);
        check_eq("t6_drop", drop_cnt, 20);
        check_eq("t6_err", err_cnt, 17);
        check_eq("t6_sat_drop", sat_drop, 4'hF);
        check_eq("t6_sat_err", sat_err, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
